serial_adder: RTL and testbench

Bit-serial adder built around the single-bit full-adder cell: one full-adder evaluation per clock on operand LSBs, carry held in a flip-flop between bits. Directly downstream of the full-adder stage; it is the sequential consumer of that cell's sum/c_out outputs. It trades WIDTH cycles of latency for one adder slice and provides a start/done handshake for the lab datapath.

---
 rtl/serial_adder_if.sv | 35 +++
 rtl/serial_adder.sv | 149 ++++++++++++++
 tb/tb_serial_adder.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_adder_if
// Request/result bundle for the bit-serial adder.
//   start  : request, sampled on rising clk
//   a, b   : operands, captured on an accepted start
//   c_in   : initial carry, captured on an accepted start
//   busy   : high while the adder is shifting
//   done   : one-cycle pulse, result valid
//   sum    : result register
//   c_out  : final carry-out
// master drives the request side, slave (the adder) drives the result side.
// -----------------------------------------------------------------------------
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
endinterface : serial_adder_if

// File: rtl/serial_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder: one full-adder slice evaluated per clock on the operand
// LSBs, with the carry held in a flip-flop between bits. An addition takes
// WIDTH clocks after the accepting edge; {c_out, sum} = a + b + c_in.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : serial_adder_if.slave (start/a/b/c_in in, busy/done/sum/c_out out)
//
// A start is accepted in IDLE or in DONE; accepting in DONE chains additions
// with no idle gap. All outputs come straight from flops.
// -----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  // Bit counter is at least one bit wide so WIDTH=1 still elaborates.
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  // Full-adder slice on the current operand LSBs.
  logic             fa_sum;
  logic             fa_cout;
  logic [WIDTH-1:0] sum_shift;

  assign fa_sum  = a_q[0] ^ b_q[0] ^ carry_q;
  assign fa_cout = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

  // New result bit enters at the MSB; after WIDTH shifts the LSB-first
  // stream has settled into natural bit order.
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_sum;
    end else begin : g_sum_wn
      assign sum_shift = {fa_sum, sum_q[WIDTH-1:1]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // this block leaves a variable unassigned, which would infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.c_in;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_SHIFT: begin
        // start and the operand inputs are ignored here; only the captured
        // copies matter until the addition completes.
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = sum_shift;
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          c_out_d = fa_cout;
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Status flags are decoded from the next state so they come out of flops
    // aligned with the state they describe.
    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: all registers here are plain flops (no storage array), so every one
  // of them is cleared by reset; an abort mid-addition leaves no stale result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values; blocking here would let a_q's shift leak into fa_sum.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_serial_adder
// Three adder instances (WIDTH 1, 8, 16) share clock and reset. Stimulus
// pushes the expected {c_out, sum} into a per-instance queue; a monitor per
// instance pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic clk;
  logic rst_n;

  int checks;
  int errors;

  serial_adder_if #(.WIDTH(1))  if1 ();
  serial_adder_if #(.WIDTH(8))  if8 ();
  serial_adder_if #(.WIDTH(16)) if16 ();

  serial_adder #(.WIDTH(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  serial_adder #(.WIDTH(8))  u_w8  (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(16)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  logic [1:0]  q1  [$];
  logic [8:0]  q8  [$];
  logic [16:0] q16 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitors
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst_n && if1.done) begin
      check("w1_done_expected", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) check("w1_result", {if1.c_out, if1.sum}, q1.pop_front());
      check("w1_busy_with_done", if1.busy, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && if8.done) begin
      check("w8_done_expected", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) check("w8_result", {if8.c_out, if8.sum}, q8.pop_front());
      check("w8_busy_with_done", if8.busy, 1'b0);
    end
  end

  always @(negedge clk) begin
    if (rst_n && if16.done) begin
      check("w16_done_expected", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) check("w16_result", {if16.c_out, if16.sum}, q16.pop_front());
      check("w16_busy_with_done", if16.busy, 1'b0);
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic logic done_of(input int w);
    case (w)
      1:       return if1.done;
      8:       return if8.done;
      default: return if16.done;
    endcase
  endfunction

  function automatic logic busy_of(input int w);
    case (w)
      1:       return if1.busy;
      8:       return if8.busy;
      default: return if16.busy;
    endcase
  endfunction

  task automatic release_start();
    if1.start  = 1'b0;
    if8.start  = 1'b0;
    if16.start = 1'b0;
  endtask

  // One addition on instance w; checks busy after the accepting edge, the
  // start-edge-to-done latency (WIDTH) and that done drops after one cycle.
  task automatic run_add(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [16:0] exp);
    int lat;
    lat = -1;
    @(negedge clk);
    case (w)
      1: begin
        if1.a = a[0]; if1.b = b[0]; if1.c_in = cin; if1.start = 1'b1;
        q1.push_back(exp[1:0]);
      end
      8: begin
        if8.a = a[7:0]; if8.b = b[7:0]; if8.c_in = cin; if8.start = 1'b1;
        q8.push_back(exp[8:0]);
      end
      default: begin
        if16.a = a; if16.b = b; if16.c_in = cin; if16.start = 1'b1;
        q16.push_back(exp);
      end
    endcase
    @(posedge clk); #1;
    release_start();
    check($sformatf("w%0d_busy_after_start", w), busy_of(w), 1'b1);
    for (int k = 1; k <= w + 2 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (done_of(w)) lat = k;
    end
    check($sformatf("w%0d_done_latency", w), lat, w);
    @(posedge clk); #1;
    check($sformatf("w%0d_done_one_cycle", w), done_of(w), 1'b0);
  endtask

  function automatic logic [16:0] model(input int w, input logic [15:0] a,
                                        input logic [15:0] b, input logic cin);
    if (w == 8) return 17'(a[7:0]) + 17'(b[7:0]) + 17'(cin);
    return 17'(a) + 17'(b) + 17'(cin);
  endfunction

  // Expected {c_out, sum} for WIDTH=1, indexed by {a, b, c_in}.
  localparam logic [1:0] FA_TABLE [8] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [15:0] ra, rb;
    logic        rc;
    int          lat;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    release_start();
    if1.a = '0;  if1.b = '0;  if1.c_in = 1'b0;
    if8.a = '0;  if8.b = '0;  if8.c_in = 1'b0;
    if16.a = '0; if16.b = '0; if16.c_in = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_w8_outputs", {if8.sum, if8.c_out, if8.busy, if8.done}, 32'd0);
    check("reset_w1_outputs", {if1.sum, if1.c_out, if1.busy, if1.done}, 32'd0);
    check("reset_w16_outputs", {if16.sum, if16.c_out, if16.busy, if16.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle with no start: everything holds at zero.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_w8_outputs", {if8.sum, if8.c_out, if8.busy, if8.done}, 32'd0);
    end

    // WIDTH=1 exhaustive full-adder truth table.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      run_add(1, {15'd0, v[2]}, {15'd0, v[1]}, v[0], {15'd0, FA_TABLE[i]});
    end

    // WIDTH=8 directed vectors.
    run_add(8, 16'h003C, 16'h0042, 1'b0, 17'h0007E);
    repeat (3) @(posedge clk);
    #1;
    check("w8_sum_holds_in_idle", {if8.c_out, if8.sum}, 9'h07E);
    run_add(8, 16'h00A5, 16'h005A, 1'b1, 17'h00100);
    run_add(8, 16'h00FF, 16'h0001, 1'b0, 17'h00100);
    run_add(8, 16'h0000, 16'h0000, 1'b1, 17'h00001);
    run_add(8, 16'h00FF, 16'h00FF, 1'b1, 17'h001FF);

    // WIDTH=16 directed vectors.
    run_add(16, 16'h1234, 16'h4321, 1'b0, 17'h05555);
    run_add(16, 16'hFFFF, 16'h0000, 1'b1, 17'h10000);

    // Back-to-back: start held high, operands changed during SHIFT.
    @(negedge clk);
    if8.a = 8'h11; if8.b = 8'h22; if8.c_in = 1'b0; if8.start = 1'b1;
    q8.push_back(9'h033);
    q8.push_back(9'h077);
    @(posedge clk); #1;
    if8.a = 8'h33; if8.b = 8'h44;
    repeat (8) @(posedge clk);
    #1;
    check("b2b_first_done_at_8", if8.done, 1'b1);
    @(posedge clk); #1;
    check("b2b_reaccept_busy", if8.busy, 1'b1);
    check("b2b_reaccept_done_low", if8.done, 1'b0);
    if8.start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      @(posedge clk); #1;
      if (if8.done) lat = k + 1;
    end
    check("b2b_done_period", lat, 9);
    @(posedge clk); #1;
    check("b2b_idle_after", {if8.busy, if8.done}, 2'b00);

    // Reset mid-SHIFT on 0xFF+0xFF aborts without a done pulse.
    @(negedge clk);
    if8.a = 8'hFF; if8.b = 8'hFF; if8.c_in = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_partial_busy", if8.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("abort_outputs_cleared", {if8.sum, if8.c_out, if8.busy, if8.done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort_no_done", if8.done, 1'b0);
    end
    run_add(8, 16'h0010, 16'h0020, 1'b0, 17'h00030);

    // Random regression at WIDTH=8 and WIDTH=16.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      run_add(8, {8'd0, ra[7:0]}, {8'd0, rb[7:0]}, rc, model(8, ra, rb, rc));
    end
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      run_add(16, ra, rb, rc, model(16, ra, rb, rc));
    end

    repeat (4) @(posedge clk);
    #1;
    check("w1_queue_drained", q1.size(), 0);
    check("w8_queue_drained", q8.size(), 0);
    check("w16_queue_drained", q16.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_adder
